// File: rtl/keypad_pkg.sv
// Shared types, sizes and key map for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = 2;
    localparam int unsigned COL_IDX_W = 2;
    localparam int unsigned CODE_W   = 4;

    // Scanner control states
    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_LOCK    = 2'd1,
        ST_EMIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Result of decoding a captured column vector
    typedef struct packed {
        logic                 valid;
        logic [COL_IDX_W-1:0] idx;
    } onehot_t;

    // Key codes indexed [row][column bit]; '*' encodes as E, '#' as F
    localparam logic [CODE_W-1:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Column vector -> index; valid only when exactly one column is set
    function automatic onehot_t onehot_index(input logic [NUM_COLS-1:0] col);
        onehot_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        case (col)
            4'b0001: begin res.valid = 1'b1; res.idx = 2'd0; end
            4'b0010: begin res.valid = 1'b1; res.idx = 2'd1; end
            4'b0100: begin res.valid = 1'b1; res.idx = 2'd2; end
            4'b1000: begin res.valid = 1'b1; res.idx = 2'd3; end
            default: begin res.valid = 1'b0; res.idx = 2'd0; end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/module_keypad_scanner_if.sv
// Key-code handshake between the scanner and the display/entry logic.
interface module_keypad_scanner_if;
    import keypad_pkg::*;

    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_error;

    // Scanner side: offers codes and error pulses
    modport master (
        output key_code,
        output key_valid,
        output key_error,
        input  key_ready
    );

    // Consumer side
    modport slave (
        input  key_code,
        input  key_valid,
        input  key_error,
        output key_ready
    );

endinterface

// File: rtl/module_keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module module_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives a settled copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad row scanner: drives rows, feeds the debouncer, and offers one
// encoded key per debounced press on a valid/ready handshake.
module module_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 27000,
    parameter int unsigned ABORT_CYCLES = 4 * SCAN_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COLS-1:0]  columnas_in,
    input  logic                 DB_out,
    input  logic [NUM_COLS-1:0]  columna_presionada,
    output logic [NUM_ROWS-1:0]  filas,
    output logic                 button_out,
    module_keypad_scanner_if.master key_if
);

    // SCAN_DIV must be at least 2
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned ABT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [ABT_W-1:0] ABT_LAST = ABT_W'(ABORT_CYCLES - 1);

    logic [NUM_COLS-1:0] col_s;

    state_t              state,     state_n;
    logic [ROW_W-1:0]    row,       row_n;
    logic [DIV_W-1:0]    div_cnt,   div_n;
    logic [ABT_W-1:0]    abort_cnt, abort_n;
    logic [CODE_W-1:0]   key_code_q, key_code_n;
    logic                key_valid_q, key_valid_n;
    logic                key_error_q, key_error_n;
    onehot_t             col_hit;

    module_sync2 #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (columnas_in),
        .q     (col_s)
    );

    assign key_if.key_code  = key_code_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_error = key_error_q;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_SCAN;
            row         <= '0;
            div_cnt     <= '0;
            abort_cnt   <= '0;
            filas       <= NUM_ROWS'(1);
            button_out  <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_error_q <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            div_cnt     <= div_n;
            abort_cnt   <= abort_n;
            filas       <= NUM_ROWS'(1) << row_n;
            button_out  <= |col_s;
            key_code_q  <= key_code_n;
            key_valid_q <= key_valid_n;
            key_error_q <= key_error_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        row_n       = row;
        div_n       = div_cnt;
        abort_n     = abort_cnt;
        key_code_n  = key_code_q;
        key_valid_n = key_valid_q;
        key_error_n = 1'b0;
        col_hit     = onehot_index(columna_presionada);

        case (state)
            ST_SCAN: begin
                // Any column activity freezes the row before a step can happen
                if (col_s != '0) begin
                    state_n = ST_LOCK;
                    abort_n = '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    row_n = row + ROW_W'(1);
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end

            ST_LOCK: begin
                abort_n = (col_s == '0) ? abort_cnt + ABT_W'(1) : '0;
                // A qualified press wins over a same-cycle abort
                if (DB_out) begin
                    if (col_hit.valid) begin
                        key_code_n  = KEYMAP[row][col_hit.idx];
                        key_valid_n = 1'b1;
                        state_n     = ST_EMIT;
                    end else begin
                        key_error_n = 1'b1;
                        state_n     = ST_RELEASE;
                    end
                end else if ((col_s == '0) && (abort_cnt == ABT_LAST)) begin
                    state_n = ST_SCAN;
                    div_n   = '0;
                end
            end

            ST_EMIT: begin
                // Key stays offered until taken, even if the press ends
                if (key_valid_q && key_if.key_ready) begin
                    key_valid_n = 1'b0;
                    state_n     = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (!DB_out) begin
                    state_n = ST_SCAN;
                    div_n   = '0;
                end
            end

            default: begin
                state_n = ST_SCAN;
                div_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Randomised self-checking bench for module_keypad_scanner with a keypad and
// debouncer stand-in and a cycle-level behavioural reference.
module tb_module_keypad_scanner;

    localparam int SCAN_DIV     = 8;
    localparam int ABORT_CYCLES = 32;

    localparam int PH_SCAN    = 0;
    localparam int PH_LOCK    = 1;
    localparam int PH_EMIT    = 2;
    localparam int PH_RELEASE = 3;

    localparam logic [3:0] KEYTAB [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] columnas_in;
    logic       DB_out;
    logic [3:0] columna_presionada;
    logic [3:0] filas;
    logic       button_out;

    module_keypad_scanner_if kif ();

    module_keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .ABORT_CYCLES (ABORT_CYCLES)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .columnas_in        (columnas_in),
        .DB_out             (DB_out),
        .columna_presionada (columna_presionada),
        .filas              (filas),
        .button_out         (button_out),
        .key_if             (kif)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;
    int  cyc = 0;

    // Physical keypad state
    bit         key_down = 1'b0;
    int         key_row = 0;
    logic [3:0] key_col = 4'b0;

    // Observed handshake statistics
    int         valid_cycles = 0;
    int         accepts = 0;
    int         errs = 0;
    logic [3:0] last_code = 4'h0;

    // Reference state
    logic [3:0] m_s1, m_s2;
    logic       m_btn, m_valid, m_err;
    logic [3:0] m_code;
    int         m_row, m_ticks, m_phase, m_quiet;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bitpos(input logic [3:0] v);
        for (int j = 0; j < 4; j++)
            if (v[j]) return j;
        return 0;
    endfunction

    // Reference: rows dwell SCAN_DIV cycles, columns seen two cycles late,
    // one key per qualified press, abort after ABORT_CYCLES quiet cycles
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= 4'b0; m_s2 <= 4'b0; m_btn <= 1'b0;
            m_row <= 0; m_ticks <= 0; m_phase <= PH_SCAN; m_quiet <= 0;
            m_code <= 4'h0; m_valid <= 1'b0; m_err <= 1'b0;
        end else begin
            m_s1  <= columnas_in;
            m_s2  <= m_s1;
            m_btn <= (m_s2 != 4'b0);
            m_err <= 1'b0;
            case (m_phase)
                PH_SCAN: begin
                    if (m_s2 != 4'b0) begin
                        m_phase <= PH_LOCK;
                        m_quiet <= 0;
                    end else if (m_ticks + 1 == SCAN_DIV) begin
                        m_ticks <= 0;
                        m_row   <= (m_row + 1) % 4;
                    end else begin
                        m_ticks <= m_ticks + 1;
                    end
                end
                PH_LOCK: begin
                    m_quiet <= (m_s2 == 4'b0) ? m_quiet + 1 : 0;
                    if (DB_out) begin
                        if ($countones(columna_presionada) == 1) begin
                            m_code  <= KEYTAB[m_row * 4 + bitpos(columna_presionada)];
                            m_valid <= 1'b1;
                            m_phase <= PH_EMIT;
                        end else begin
                            m_err   <= 1'b1;
                            m_phase <= PH_RELEASE;
                        end
                    end else if (m_s2 == 4'b0 && m_quiet + 1 == ABORT_CYCLES) begin
                        m_phase <= PH_SCAN;
                        m_ticks <= 0;
                    end
                end
                PH_EMIT: begin
                    if (kif.key_ready) begin
                        m_valid <= 1'b0;
                        m_phase <= PH_RELEASE;
                    end
                end
                default: begin
                    if (!DB_out) begin
                        m_phase <= PH_SCAN;
                        m_ticks <= 0;
                    end
                end
            endcase
        end
    end

    // Compare DUT against reference every cycle, and gather handshake stats
    always @(negedge clk) begin
        if (chk_on) begin
            check("filas",      32'(filas),          32'(4'b0001 << m_row));
            check("button_out", 32'(button_out),     32'(m_btn));
            check("key_valid",  32'(kif.key_valid),  32'(m_valid));
            check("key_error",  32'(kif.key_error),  32'(m_err));
            check("key_code",   32'(kif.key_code),   32'(m_code));
            if (kif.key_valid) valid_cycles++;
            if (kif.key_valid && kif.key_ready) begin
                accepts++;
                last_code = kif.key_code;
            end
            if (kif.key_error) errs++;
        end
    end

    // One clock: advance, then update the column lines from the pressed key
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        columnas_in = (key_down && filas == (4'b0001 << key_row)) ? key_col : 4'b0;
    endtask

    task automatic rand_step();
        step();
        kif.key_ready = 1'($urandom_range(0, 1));
    endtask

    // Press a key just as its row becomes active
    task automatic press_key(input int row, input logic [3:0] col, output int edge_at);
        logic [3:0] tgt;
        logic [3:0] prev;
        bit         ok;
        tgt = 4'b0001 << row;
        prev = filas;
        ok = 1'b0;
        edge_at = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (filas == tgt && prev != tgt) begin
                key_row = row; key_col = col; key_down = 1'b1;
                columnas_in = col;
                edge_at = cyc;
                ok = 1'b1;
                break;
            end
            prev = filas;
        end
        check("press_row_reached", 32'(ok), 32'(1));
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (kif.key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'(1));
    endtask

    initial begin
        int v0, a0, e0, eg, cnt, r, mode;
        logic [3:0] c;
        columnas_in = 4'b0; DB_out = 1'b0; columna_presionada = 4'b0;
        kif.key_ready = 1'b0;

        // Reset values
        #1 reset = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_filas", 32'(filas), 32'(4'b0001));
        check("rst_valid", 32'(kif.key_valid), 32'(0));
        check("rst_code",  32'(kif.key_code), 32'(0));
        check("rst_btn",   32'(button_out), 32'(0));
        reset = 1'b0;

        // Idle scan: row 0 for 8 cycles, then 1, wrap after 32
        repeat (7) step();
        @(negedge clk); check("idle_row0_end", 32'(filas), 32'(4'b0001));
        step();
        @(negedge clk); check("idle_row1", 32'(filas), 32'(4'b0010));
        repeat (24) step();
        @(negedge clk); check("idle_wrap", 32'(filas), 32'(4'b0001));
        check("idle_no_key", 32'(valid_cycles), 32'(0));

        // Key "6" with consumer always ready
        kif.key_ready = 1'b1;
        press_key(1, 4'b0100, eg);
        repeat (20) step();
        DB_out = 1'b1; columna_presionada = 4'b0100;
        v0 = valid_cycles; a0 = accepts;
        repeat (15) step();
        @(negedge clk);
        check("k6_frozen", 32'(filas), 32'(4'b0010));
        check("k6_one_pulse", 32'(valid_cycles - v0), 32'(1));
        check("k6_accepted", 32'(accepts - a0), 32'(1));
        check("k6_code", 32'(last_code), 32'(4'h6));
        key_down = 1'b0;
        repeat (5) step();
        DB_out = 1'b0; columna_presionada = 4'b0;
        repeat (3) step();
        @(negedge clk);
        check("k6_no_repeat", 32'(valid_cycles - v0), 32'(1));

        // "#" under backpressure, press ends while the key is held
        kif.key_ready = 1'b0;
        press_key(3, 4'b0100, eg);
        repeat (20) step();
        DB_out = 1'b1; columna_presionada = 4'b0100;
        wait_valid("bp_valid_seen");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (kif.key_valid && kif.key_code == 4'hF) cnt++;
            step();
            if (i == 10) begin
                DB_out = 1'b0; key_down = 1'b0; columna_presionada = 4'b0;
            end
        end
        check("bp_hold", 32'(cnt), 32'(30));
        a0 = accepts;
        kif.key_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_accept", 32'(accepts - a0), 32'(1));
        check("bp_code", 32'(last_code), 32'(4'hF));
        check("bp_valid_drop", 32'(kif.key_valid), 32'(0));
        repeat (8) step();
        @(negedge clk); check("bp_rescan_row3", 32'(filas), 32'(4'b1000));
        step();
        @(negedge clk); check("bp_rescan_row0", 32'(filas), 32'(4'b0001));

        // Bounce that never qualifies: abort after 32 quiet cycles
        v0 = valid_cycles; e0 = errs;
        press_key(1, 4'b0010, eg);
        repeat (2) step();
        key_down = 1'b0;
        while (cyc < eg + 44) step();
        @(negedge clk); check("abort_still_frozen", 32'(filas), 32'(4'b0010));
        step();
        @(negedge clk); check("abort_resumed", 32'(filas), 32'(4'b0100));
        check("abort_no_key", 32'(valid_cycles - v0), 32'(0));
        check("abort_no_err", 32'(errs - e0), 32'(0));

        // Ghosting: two columns captured
        v0 = valid_cycles; e0 = errs;
        press_key(2, 4'b0110, eg);
        repeat (10) step();
        DB_out = 1'b1; columna_presionada = 4'b0110;
        repeat (5) step();
        @(negedge clk);
        check("ghost_err_pulse", 32'(errs - e0), 32'(1));
        check("ghost_no_key", 32'(valid_cycles - v0), 32'(0));
        key_down = 1'b0; DB_out = 1'b0; columna_presionada = 4'b0;
        repeat (12) step();

        // Reset while a key is offered
        kif.key_ready = 1'b0;
        press_key(0, 4'b0001, eg);
        repeat (8) step();
        DB_out = 1'b1; columna_presionada = 4'b0001;
        wait_valid("rst_emit_valid_seen");
        check("rst_emit_code", 32'(kif.key_code), 32'(4'h1));
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(kif.key_valid), 32'(0));
        check("rst_async_filas", 32'(filas), 32'(4'b0001));
        DB_out = 1'b0; key_down = 1'b0; columna_presionada = 4'b0;
        repeat (2) step();
        @(negedge clk);
        reset = 1'b0;
        v0 = valid_cycles;
        kif.key_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        check("rst_no_stale_key", 32'(valid_cycles - v0), 32'(0));

        // Random presses, bounces, ghosts and consumer stalls
        for (int it = 0; it < 25; it++) begin
            r    = $urandom_range(0, 3);
            c    = 4'($urandom_range(1, 15));
            mode = $urandom_range(0, 3);
            press_key(r, c, eg);
            if (mode == 0) begin
                repeat (2) rand_step();
                key_down = 1'b0;
            end else begin
                repeat ($urandom_range(2, 12)) rand_step();
                DB_out = 1'b1; columna_presionada = c;
                repeat ($urandom_range(3, 20)) rand_step();
                key_down = 1'b0; DB_out = 1'b0; columna_presionada = 4'b0;
            end
            repeat (50) rand_step();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #5000000;
        bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_keypad_scanner.md
Name: module_keypad_scanner

Overview:
Drives the 4x4 keypad rows, synchronises the raw column lines, and feeds the debouncer its button_in. It consumes the debouncer's DB_out/columna_presionada, encodes row+column into a 4-bit key code, and offers that code on a valid/ready handshake to the downstream consumer (display/entry logic). It wraps around module_DeBounce: it sits upstream on button_in and downstream on DB_out.

Parameters:
SCAN_DIV, 27000, clk cycles per row step (1 ms at 27 MHz); minimum 2.
ABORT_CYCLES, 4*SCAN_DIV, consecutive cycles of zero columns in LOCK before resuming the scan.

Ports:
clk  in  1  system clock (27 MHz)
reset  in  1  asynchronous, active-high reset
columnas_in  in  4  raw keypad column lines, active-high, asynchronous
DB_out  in  1  debounced press level from the debouncer
columna_presionada  in  4  column vector captured by the debouncer
filas  out  4  row drive, one-hot, active-high
button_out  out  1  |columnas after the 2-FF synchroniser; drives the debouncer's button_in
key_code  out  4  encoded key; stable while key_valid=1
key_valid  out  1  key offered to the consumer
key_ready  in  1  consumer accepts when key_valid&key_ready at the rising clk edge
key_error  out  1  one-cycle pulse: captured column not one-hot (0 or multiple keys)

Behaviour:
- Reset values (async, immediate): filas=4'b0001, row=0, state=SCAN, div_cnt=0, key_code=0, key_valid=0, key_error=0, button_out=0, synchroniser flops=0.
- columnas_in passes through a 2-FF synchroniser to give col_s. button_out=|col_s, registered, so total latency is 3 cycles from the pin.
- div_cnt width is $clog2(SCAN_DIV). It counts 0..SCAN_DIV-1 only in SCAN; it is cleared on entry to SCAN.
- filas = 1<<row, registered. Row order is 0,1,2,3,0 (wrap).
- SCAN:
  - If col_s!=0, go to LOCK and freeze the row. This check has priority over a same-cycle row step.
  - Else, when div_cnt==SCAN_DIV-1, advance row mod 4.
- LOCK:
  - Row stays frozen.
  - An abort counter counts cycles with col_s==0 and clears whenever col_s!=0.
  - If DB_out==1: sample columna_presionada.
    - If one-hot: key_code=KEYMAP[row][col] and key_valid=1 on the next edge, then go to EMIT.
    - Else: key_error=1 for one cycle, then go to RELEASE.
  - Else if the abort counter reaches ABORT_CYCLES-1 (bounce that never qualified): go to SCAN without emitting.
  - DB_out has priority over abort in the same cycle.
- EMIT:
  - Hold key_valid and key_code until key_valid&key_ready.
  - On acceptance: key_valid=0 on the next edge, then go to RELEASE.
  - DB_out falling during EMIT does not withdraw the key.
- RELEASE: row stays frozen. When DB_out==0, go to SCAN (div_cnt=0, row unchanged), so each press yields exactly one key.
- key_ready high while key_valid=0 has no effect. key_ready constantly high gives a one-cycle key_valid.
- KEYMAP (row, col bit0..3):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
  - Column bit i maps to index i; one-hot check is on 4 bits.
- Reset asserted mid-EMIT drops key_valid immediately; no key is re-offered after release of reset.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, LOCK, EMIT, RELEASE), 2 bits
  - NUM_ROWS=4, NUM_COLS=4
  - KEYMAP constant array [4][4] of 4-bit codes
  - function onehot_index(col) returning a valid flag and a 2-bit index
- Sub-module module_sync2: parameterised-width 2-FF synchroniser with async active-high reset, used for columnas_in.

Test Plan:
- Reset then idle with columnas_in=0 (use SCAN_DIV=8) -> filas cycles 0001,0010,0100,1000,0001 every 8 cycles; key_valid stays 0.
- Key "6": drive columnas_in=4'b0100 only when filas==4'b0010; model DB_out=1 with columna_presionada=4'b0100 after 20 cycles; key_ready=1 -> filas frozen at 0010, one key_valid pulse with key_code=4'h6, no further pulse until DB_out=0.
- Backpressure: press "#" (row3, col 4'b0100) with key_ready=0 for 30 cycles, DB_out dropping meanwhile -> key_valid=1, key_code=4'hF held stable all 30 cycles; accepted when key_ready=1; state returns to SCAN the following cycles.
- Bounce abort (ABORT_CYCLES=32): columnas_in high 3 cycles then 0, DB_out never asserts -> after 32 zero cycles scanning resumes from the frozen row; key_valid and key_error stay 0.
- Ghosting: DB_out=1 with columna_presionada=4'b0110 -> key_error single-cycle pulse, no key_valid; return to SCAN after DB_out=0.
- Reset mid-EMIT: assert reset while key_valid=1 -> key_valid=0 and filas=0001 asynchronously; after reset release, scanning restarts at row 0 with no stale key.
